// File: rtl/ups_pkg.sv
// Shared constants, state encodings and the word-offset decoder for the UPS
// AXI4-Lite register bank.
package ups_pkg;

    localparam int REG_W   = 32;
    localparam int DEC_LSB = 2;
    localparam int DEC_MSB = 11;
    localparam int DEC_W   = DEC_MSB - DEC_LSB + 1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} write_state_t;
    typedef enum logic       {R_IDLE, R_DATA}                 read_state_t;
    typedef enum logic [1:0] {KIND_CTRL, KIND_STAT, KIND_NONE} reg_kind_t;

    // Control registers come first, status registers follow, the rest is a hole.
    function automatic reg_kind_t decode_off(input logic [DEC_W-1:0] off,
                                             input int n_ctrl, input int n_stat);
        int o;
        o = int'(off);
        if (o < n_ctrl)          return KIND_CTRL;
        if (o < n_ctrl + n_stat) return KIND_STAT;
        return KIND_NONE;
    endfunction

endpackage

// File: rtl/ups_regs_rd.sv
// Read side of the register bank: AR/R handshake FSM, offset decode and the
// registered read mux over control storage and live status inputs.
module ups_regs_rd
    import ups_pkg::*;
#(
    parameter int N_CTRL = 8,
    parameter int N_STAT = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic [N_CTRL*REG_W-1:0]                    data,
    input  logic [((N_STAT > 0) ? N_STAT : 1)*REG_W-1:0] stat,
    input  logic [31:0]                                ca4l_araddr,
    input  logic                                       ca4l_arvalid,
    output logic                                       ca4l_arready,
    output logic [31:0]                                ca4l_rdata,
    output logic [1:0]                                 ca4l_rresp,
    output logic                                       ca4l_rvalid,
    input  logic                                       ca4l_rready
);

    read_state_t      state, state_next;
    logic [DEC_W-1:0] off;
    reg_kind_t        kind;
    logic [REG_W-1:0] rd_word;
    logic             ar_hs;
    logic             unused_addr;

    assign off         = ca4l_araddr[DEC_MSB:DEC_LSB];
    assign unused_addr = ^{ca4l_araddr[31:DEC_MSB+1], ca4l_araddr[DEC_LSB-1:0]};
    assign kind        = decode_off(off, N_CTRL, N_STAT);
    assign ar_hs       = ca4l_arvalid && ca4l_arready;
    assign ca4l_rvalid = (state == R_DATA);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_CTRL; k++)
            if (off == DEC_W'(k)) rd_word = data[k*REG_W +: REG_W];
        for (int k = 0; k < N_STAT; k++)
            if (off == DEC_W'(N_CTRL + k)) rd_word = stat[k*REG_W +: REG_W];
    end

    always_comb begin
        state_next   = state;
        ca4l_arready = 1'b0;
        case (state)
            R_IDLE: begin
                ca4l_arready = en;
                if (en && ca4l_arvalid) state_next = R_DATA;
            end
            R_DATA: if (ca4l_rready) state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_next;
    end

    // rdata/rresp only move on an AR handshake, so they hold while rready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca4l_rdata <= '0;
            ca4l_rresp <= AXI_RESP_OKAY;
        end else if (ar_hs) begin
            ca4l_rdata <= (kind == KIND_NONE) ? '0 : rd_word;
            ca4l_rresp <= (kind == KIND_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
    end

endmodule

// File: rtl/ups_regs.sv
// Parametrised AXI4-Lite control/status register bank for the UPS PL: write
// FSM, byte-strobed control storage with commit pulses, read path in ups_regs_rd.
module ups_regs
    import ups_pkg::*;
#(
    parameter int N_CTRL = 8,
    parameter int N_STAT = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic [N_CTRL*REG_W-1:0]                    data,
    output logic [N_CTRL-1:0]                          dv,
    input  logic [((N_STAT > 0) ? N_STAT : 1)*REG_W-1:0] stat,
    input  logic [31:0]                                ca4l_araddr,
    input  logic                                       ca4l_arvalid,
    output logic                                       ca4l_arready,
    input  logic [31:0]                                ca4l_awaddr,
    input  logic                                       ca4l_awvalid,
    output logic                                       ca4l_awready,
    input  logic [31:0]                                ca4l_wdata,
    input  logic [3:0]                                 ca4l_wstrb,
    input  logic                                       ca4l_wvalid,
    output logic                                       ca4l_wready,
    output logic [1:0]                                 ca4l_bresp,
    output logic                                       ca4l_bvalid,
    input  logic                                       ca4l_bready,
    output logic [31:0]                                ca4l_rdata,
    output logic [1:0]                                 ca4l_rresp,
    output logic                                       ca4l_rvalid,
    input  logic                                       ca4l_rready
);

    write_state_t     w_state, w_next;
    logic             en;
    logic             commit;
    logic [DEC_W-1:0] aw_off_q, c_off;
    logic [REG_W-1:0] wdata_q, c_data;
    logic [3:0]       wstrb_q, c_strb;
    reg_kind_t        c_kind;
    logic             unused_addr;

    assign unused_addr = ^{ca4l_awaddr[31:DEC_MSB+1], ca4l_awaddr[DEC_LSB-1:0]};
    assign ca4l_bvalid = (w_state == W_RESP);

    // Whichever half arrived first comes from its capture register, the other is live.
    assign c_off  = (w_state == W_ADDR) ? aw_off_q : ca4l_awaddr[DEC_MSB:DEC_LSB];
    assign c_data = (w_state == W_DATA) ? wdata_q  : ca4l_wdata;
    assign c_strb = (w_state == W_DATA) ? wstrb_q  : ca4l_wstrb;
    assign c_kind = decode_off(c_off, N_CTRL, N_STAT);

    always_comb begin
        w_next       = w_state;
        ca4l_awready = 1'b0;
        ca4l_wready  = 1'b0;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                ca4l_awready = en;
                ca4l_wready  = en;
                if (en && ca4l_awvalid && ca4l_wvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (en && ca4l_awvalid) begin
                    w_next = W_ADDR;
                end else if (en && ca4l_wvalid) begin
                    w_next = W_DATA;
                end
            end
            W_ADDR: begin
                ca4l_wready = 1'b1;
                if (ca4l_wvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_DATA: begin
                ca4l_awready = 1'b1;
                if (ca4l_awvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_RESP: if (ca4l_bready) w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // NOTE: the control bank is small flop storage, not RAM, so it is cleared by
    // reset; en is a flop rather than ~rst so readies rise one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en         <= 1'b0;
            data       <= '0;
            dv         <= '0;
            ca4l_bresp <= AXI_RESP_OKAY;
            aw_off_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            en <= 1'b1;
            dv <= '0;
            if (ca4l_awvalid && ca4l_awready) aw_off_q <= ca4l_awaddr[DEC_MSB:DEC_LSB];
            if (ca4l_wvalid && ca4l_wready) begin
                wdata_q <= ca4l_wdata;
                wstrb_q <= ca4l_wstrb;
            end
            if (commit) begin
                ca4l_bresp <= (c_kind == KIND_CTRL) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                for (int k = 0; k < N_CTRL; k++) begin
                    if (c_kind == KIND_CTRL && c_off == DEC_W'(k)) begin
                        dv[k] <= 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (c_strb[b]) data[k*REG_W + b*8 +: 8] <= c_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    ups_regs_rd #(
        .N_CTRL (N_CTRL),
        .N_STAT (N_STAT)
    ) u_rd (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .data         (data),
        .stat         (stat),
        .ca4l_araddr  (ca4l_araddr),
        .ca4l_arvalid (ca4l_arvalid),
        .ca4l_arready (ca4l_arready),
        .ca4l_rdata   (ca4l_rdata),
        .ca4l_rresp   (ca4l_rresp),
        .ca4l_rvalid  (ca4l_rvalid),
        .ca4l_rready  (ca4l_rready)
    );

endmodule
